// File: rtl/gamepad_event_queue.sv
// Purpose: turn per-button press/release transitions between successive gamepad snapshots into 8-bit events held in a FIFO.
// Latency: a snapshot change captured at edge N pushes bit i at edge N+1+i; the FIFO head is first-word-fall-through.
// Backpressure: no stall; a push into a full FIFO is dropped and sets sticky overflow, unless a pop happens on the same cycle.
module gamepad_event_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [23:0]              pad_data,
    input  logic                     enable,
    input  logic                     rd_en,
    input  logic                     clear,
    output logic [7:0]               ev_data,
    output logic                     ev_valid,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        r_state;
    logic [23:0]   r_prev;
    logic [23:0]   r_new;
    logic [23:0]   r_diff;
    logic [4:0]    r_idx;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_c1_present;
    logic          w_c2_present;
    logic [23:0]   w_diff_raw;
    logic [23:0]   w_diff_masked;
    logic          w_ctrl;
    logic [3:0]    w_bit_idx;
    logic [7:0]    w_event;
    logic          w_push;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;

    // A controller reading all ones is unplugged; transitions into or out of that state are not button events.
    assign w_c1_present  = (r_prev[11:0]  != 12'hFFF) && (pad_data[11:0]  != 12'hFFF);
    assign w_c2_present  = (r_prev[23:12] != 12'hFFF) && (pad_data[23:12] != 12'hFFF);
    assign w_diff_raw    = pad_data ^ r_prev;
    assign w_diff_masked = {w_c2_present ? w_diff_raw[23:12] : 12'h000,
                            w_c1_present ? w_diff_raw[11:0]  : 12'h000};

    assign w_ctrl    = (r_idx >= 5'd12);
    assign w_bit_idx = w_ctrl ? 4'(r_idx - 5'd12) : r_idx[3:0];
    assign w_event   = {r_new[r_idx], w_ctrl, 2'b00, w_bit_idx};
    assign w_push    = (r_state == SCAN) && r_diff[r_idx];

    // A pop on a full FIFO frees the slot that a same-cycle push then takes.
    assign w_full    = (r_count == CNT_FULL);
    assign w_pop     = rd_en && (r_count != '0);
    assign w_push_ok = w_push && (!w_full || rd_en);

    assign ev_valid = (r_count != '0);
    assign ev_data  = ev_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign ev_count = r_count;
    assign overflow = r_overflow;
    assign busy     = (r_state == SCAN);

    // Snapshot tracker and bit scanner; clear aborts a scan but keeps the last capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_prev  <= 24'hFFFFFF;
            r_new   <= 24'h000000;
            r_diff  <= 24'h000000;
            r_idx   <= 5'd0;
        end else if (clear) begin
            r_state <= IDLE;
            r_diff  <= 24'h000000;
            r_idx   <= 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pad_data != r_prev) begin
                        r_prev <= pad_data;
                        r_new  <= pad_data;
                        r_idx  <= 5'd0;
                        if (enable) begin
                            r_diff  <= w_diff_masked;
                            r_state <= SCAN;
                        end else begin
                            r_diff  <= 24'h000000;
                        end
                    end
                end
                SCAN: begin
                    if (r_idx == 5'd23) begin
                        r_state <= IDLE;
                        r_idx   <= 5'd0;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Event FIFO with sticky overflow; clear discards any push or pop on its cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_event;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gamepad_event_queue.sv
// Purpose: directed self-checking bench for gamepad_event_queue with hand-computed event sequences.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: reads are issued explicitly by the bench; overflow and same-cycle push/pop are exercised directly.
module tb_gamepad_event_queue;

    logic        clk;
    logic        rst;
    logic [23:0] pad_data;
    logic        enable;
    logic        rd_en;
    logic        clear;
    logic [7:0]  ev_data;
    logic        ev_valid;
    logic [3:0]  ev_count;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cycles;

    gamepad_event_queue #(.DEPTH(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .pad_data (pad_data),
        .enable   (enable),
        .rd_en    (rd_en),
        .clear    (clear),
        .ev_data  (ev_data),
        .ev_valid (ev_valid),
        .ev_count (ev_count),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check(tag, 32'(ev_data), 32'(exp));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pad_data = 24'hFFFFFF; enable = 1'b1; rd_en = 1'b0; clear = 1'b0;
        wait_n(3);
        check("rst_count", 32'(ev_count), 32'd0);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_data",  32'(ev_data),  32'h00);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        rst = 1'b0;
        tick();

        // Controller 1 appears: no events; then a single press of bit 0.
        pad_data = 24'hFFF000;
        wait_n(30);
        check("connect1_count", 32'(ev_count), 32'd0);
        pad_data = 24'hFFF001;
        busy_cycles = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (busy) busy_cycles++;
            if (k == 1) check("press_lat1_valid", 32'(ev_valid), 32'd0);
            if (k == 2) begin
                check("press_lat2_valid", 32'(ev_valid), 32'd1);
                check("press_lat2_data",  32'(ev_data),  32'h80);
            end
        end
        check("press_busy_cycles", 32'(busy_cycles), 32'd24);
        check("press_count", 32'(ev_count), 32'd1);
        pop_expect("press_ev", 8'h80);
        check("press_empty", 32'(ev_valid), 32'd0);

        // Release plus press across both controllers.
        pad_data = 24'h000004;
        wait_n(30);
        do_clear();
        check("t2_clr_count", 32'(ev_count), 32'd0);
        pad_data = 24'h200001;
        wait_n(30);
        check("t2_count", 32'(ev_count), 32'd3);
        pop_expect("t2_ev0", 8'h80);
        pop_expect("t2_ev1", 8'h02);
        pop_expect("t2_ev2", 8'hC9);
        check("t2_empty", 32'(ev_valid), 32'd0);

        // Ten presses into an eight-entry FIFO.
        pad_data = 24'h000000;
        wait_n(30);
        do_clear();
        pad_data = 24'h0003FF;
        wait_n(30);
        check("ovf_count", 32'(ev_count), 32'd8);
        check("ovf_flag",  32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) pop_expect("ovf_ev", 8'(8'h80 + i));
        check("ovf_sticky", 32'(overflow), 32'd1);
        do_clear();
        check("clr_count", 32'(ev_count), 32'd0);
        check("clr_ovf",   32'(overflow), 32'd0);
        check("clr_valid", 32'(ev_valid), 32'd0);
        check("clr_data",  32'(ev_data),  32'h00);

        // Disconnect, connect, disconnect of controller 1.
        pad_data = 24'h000FFF;
        wait_n(30);
        check("disc1_count", 32'(ev_count), 32'd0);
        pad_data = 24'h000010;
        wait_n(30);
        check("conn_count", 32'(ev_count), 32'd0);
        pad_data = 24'h000FFF;
        wait_n(30);
        check("disc2_count", 32'(ev_count), 32'd0);
        check("disc2_ovf",   32'(overflow), 32'd0);

        // Silent tracking while disabled.
        pad_data = 24'h000000;
        wait_n(30);
        check("dis_pre_count", 32'(ev_count), 32'd0);
        enable = 1'b0;
        pad_data = 24'h000002;
        wait_n(2);
        check("dis_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_n(30);
        check("dis_count", 32'(ev_count), 32'd0);
        check("dis_busy_after", 32'(busy), 32'd0);

        // Fill to full, then pop in the same cycle as the ninth push (bit 9).
        pad_data = 24'h0003FF;
        wait_n(10);
        check("sim_full_count", 32'(ev_count), 32'd8);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("sim_count", 32'(ev_count), 32'd8);
        check("sim_ovf",   32'(overflow), 32'd0);
        wait_n(20);
        check("sim_ovf_end", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) pop_expect("sim_ev", 8'(8'h82 + i));
        check("sim_empty", 32'(ev_valid), 32'd0);

        // Reset in the middle of a 12-event scan.
        pad_data = 24'h000C00;
        wait_n(6);
        check("mid_busy",  32'(busy),     32'd1);
        check("mid_count", 32'(ev_count), 32'd5);
        rst = 1'b1;
        tick();
        check("rst2_busy",  32'(busy),     32'd0);
        check("rst2_count", 32'(ev_count), 32'd0);
        check("rst2_valid", 32'(ev_valid), 32'd0);
        check("rst2_ovf",   32'(overflow), 32'd0);
        pad_data = 24'hFFFFFF;
        tick();
        rst = 1'b0;
        wait_n(2);
        check("rst2_prev_busy",  32'(busy),     32'd0);
        check("rst2_prev_count", 32'(ev_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
